// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the demux select sequencer and its helpers.
package demux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage : demux_seq_pkg

// File: rtl/demux_sel_sequencer_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : sat_counter

// File: rtl/demux_sel_sequencer.sv
// Drives registered select/data pairs into a 1-to-4 demux and counts delivered 1-bits per channel.
// Optional post-item idle cycle enabled by defining DEMUX_SEQ_GAP_EN.
module demux_sel_sequencer
  import demux_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_data,
  input  logic [SEL_W-1:0]        in_dest,
  input  logic                    mode,
  output logic [SEL_W-1:0]        s,
  output logic                    I,
  output logic                    busy,
  output logic [NUM_CH*CNT_W-1:0] cnt_flat
);

  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q,  hold_d;
  logic [SEL_W-1:0]   rr_q,    rr_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic               data_q,  data_d;

  logic               accept;
  logic [SEL_W-1:0]   acc_dest;
  logic [NUM_CH-1:0]  inc;

  assign accept   = in_valid && in_ready;
  assign acc_dest = mode ? rr_q : in_dest;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rr_q    <= '0;
      sel_q   <= '0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    data_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRIVE;
          hold_d  = HOLD_W'(1);
          sel_d   = acc_dest;
          data_d  = in_data;
          if (mode) begin
            rr_d = rr_q + SEL_W'(1);
          end
        end
      end
      DRIVE: begin
        if (hold_q == HOLD_LAST) begin
`ifdef DEMUX_SEQ_GAP_EN
          state_d = GAP;
`else
          state_d = IDLE;
`endif
        end else begin
          hold_d = hold_q + HOLD_W'(1);
          data_d = data_q;
        end
      end
`ifdef DEMUX_SEQ_GAP_EN
      // Select stays on dest with data low so the demux output settles before s moves.
      GAP: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake status depends on the state register only, never on in_valid.
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  assign s = sel_q;
  assign I = data_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign inc[k] = accept && in_data && (acc_dest == SEL_W'(k));

    sat_counter #(
      .W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[k]),
      .q     (cnt_flat[k*CNT_W +: CNT_W])
    );
  end

endmodule : demux_sel_sequencer

// File: tb/tb_demux_sel_sequencer.sv
// Directed bench: instance A (HOLD_CYCLES=1, CNT_W=8) and instance B (HOLD_CYCLES=4, CNT_W=2).
module tb_demux_sel_sequencer;

`ifdef DEMUX_SEQ_GAP_EN
  localparam int GAP_CYC = 1;
`else
  localparam int GAP_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_data, a_mode, a_i, a_busy;
  logic [1:0]  a_dest, a_s;
  logic [31:0] a_cnt;
  logic        b_valid, b_ready, b_data, b_mode, b_i, b_busy;
  logic [1:0]  b_dest, b_s;
  logic [7:0]  b_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt [2][4];

  demux_sel_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .in_dest(a_dest), .mode(a_mode), .s(a_s), .I(a_i), .busy(a_busy), .cnt_flat(a_cnt)
  );

  demux_sel_sequencer #(.HOLD_CYCLES(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_dest(b_dest), .mode(b_mode), .s(b_s), .I(b_i), .busy(b_busy), .cnt_flat(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] o_s(input bit b);
    return b ? 32'(b_s) : 32'(a_s);
  endfunction
  function automatic logic [31:0] o_i(input bit b);
    return b ? 32'(b_i) : 32'(a_i);
  endfunction
  function automatic logic [31:0] o_busy(input bit b);
    return b ? 32'(b_busy) : 32'(a_busy);
  endfunction
  function automatic logic [31:0] o_ready(input bit b);
    return b ? 32'(b_ready) : 32'(a_ready);
  endfunction
  function automatic logic [31:0] o_cnt(input bit b, input int k);
    return b ? 32'(b_cnt[k*2 +: 2]) : 32'(a_cnt[k*8 +: 8]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input bit b, input int c0, input int c1, input int c2, input int c3);
    int c [4];
    c = '{c0, c1, c2, c3};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cnt_%s%0d", b ? "b" : "a", k), o_cnt(b, k), 32'(c[k]));
    end
  endtask

  // Offers one item, then checks every cycle of DRIVE (and GAP) plus the return to IDLE.
  task automatic send(input bit b, input bit mode_i, input logic [1:0] dest_i, input bit data_i,
                      input logic [1:0] exp_s, input bit keep);
    int    hold;
    int    cmax;
    string n;
    hold = b ? 4 : 1;
    cmax = b ? 3 : 255;
    n    = b ? "b" : "a";
    if (b) begin
      b_valid = 1'b1; b_mode = mode_i; b_dest = dest_i; b_data = data_i;
    end else begin
      a_valid = 1'b1; a_mode = mode_i; a_dest = dest_i; a_data = data_i;
    end
    check({n, "_ready_pre"}, o_ready(b), 32'd1);
    tick;
    if (!keep) begin
      if (b) b_valid = 1'b0; else a_valid = 1'b0;
    end
    if (data_i && exp_cnt[b][exp_s] < cmax) exp_cnt[b][exp_s]++;
    check({n, "_cnt_acc"}, o_cnt(b, int'(exp_s)), 32'(exp_cnt[b][exp_s]));
    for (int h = 0; h < hold; h++) begin
      check($sformatf("%s_drv%0d_s", n, h), o_s(b), 32'(exp_s));
      check($sformatf("%s_drv%0d_i", n, h), o_i(b), 32'(data_i));
      check($sformatf("%s_drv%0d_busy", n, h), o_busy(b), 32'd1);
      check($sformatf("%s_drv%0d_ready", n, h), o_ready(b), 32'd0);
      tick;
    end
    if (GAP_CYC != 0) begin
      check({n, "_gap_s"}, o_s(b), 32'(exp_s));
      check({n, "_gap_i"}, o_i(b), 32'd0);
      check({n, "_gap_busy"}, o_busy(b), 32'd1);
      check({n, "_gap_ready"}, o_ready(b), 32'd0);
      tick;
    end
    check({n, "_idle_s"}, o_s(b), 32'(exp_s));
    check({n, "_idle_i"}, o_i(b), 32'd0);
    check({n, "_idle_busy"}, o_busy(b), 32'd0);
    check({n, "_idle_ready"}, o_ready(b), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    for (int b = 0; b < 2; b++) begin
      check($sformatf("%s%0d_s", tag, b), o_s(b[0]), 32'd0);
      check($sformatf("%s%0d_i", tag, b), o_i(b[0]), 32'd0);
      check($sformatf("%s%0d_busy", tag, b), o_busy(b[0]), 32'd0);
      check($sformatf("%s%0d_ready", tag, b), o_ready(b[0]), 32'd1);
      check_counts(b[0], 0, 0, 0, 0);
    end
  endtask

  task automatic pulse_reset;
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("rst");
    tick;
    rst_n = 1'b1;
    for (int b = 0; b < 2; b++) for (int k = 0; k < 4; k++) exp_cnt[b][k] = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b1; a_data = 1'b1; a_mode = 1'b0; a_dest = 2'd1;
    b_valid = 1'b0; b_data = 1'b0; b_mode = 1'b0; b_dest = 2'd0;
    for (int b = 0; b < 2; b++) for (int k = 0; k < 4; k++) exp_cnt[b][k] = 0;

    // Reset values, with in_valid high on A across an edge while held in reset.
    #1;
    check_reset_state("por");
    tick;
    check("por_valid_ignored_busy", o_busy(1'b0), 32'd0);
    check("por_valid_ignored_cnt", o_cnt(1'b0, 1), 32'd0);
    a_valid = 1'b0;
    rst_n   = 1'b1;
    tick;

    // Addressed item: dest 2, data 1.
    send(1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 1'b0);
    check_counts(1'b0, 0, 0, 1, 0);

    // Round-robin stream, in_valid held high, in_dest=3 ignored.
    pulse_reset;
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 1'b1, 2'd3, 1'b1, 2'(i % 4), i < 5);
    end
    a_valid = 1'b0;
    check_counts(1'b0, 2, 2, 1, 1);

    // Mixed modes: addressed item leaves the pointer alone; data-0 items do not count.
    pulse_reset;
    send(1'b0, 1'b1, 2'd3, 1'b1, 2'd0, 1'b0);
    send(1'b0, 1'b1, 2'd2, 1'b0, 2'd1, 1'b0);
    send(1'b0, 1'b0, 2'd3, 1'b1, 2'd3, 1'b0);
    send(1'b0, 1'b1, 2'd0, 1'b1, 2'd2, 1'b0);
    check_counts(1'b0, 1, 0, 1, 1);

    // HOLD_CYCLES=4, back-to-back addressed items.
    send(1'b1, 1'b0, 2'd1, 1'b1, 2'd1, 1'b1);
    send(1'b1, 1'b0, 2'd2, 1'b1, 2'd2, 1'b0);
    check_counts(1'b1, 0, 1, 1, 0);

    // CNT_W=2 saturation on channel 1.
    pulse_reset;
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0, 2'd1, 1'b1, 2'd1, 1'b0);
    end
    check_counts(1'b1, 0, 3, 0, 0);

    // Reset in the middle of DRIVE.
    send(1'b0, 1'b1, 2'd3, 1'b1, 2'd0, 1'b0);
    a_valid = 1'b1; a_mode = 1'b1; a_data = 1'b1; a_dest = 2'd0;
    tick;
    a_valid = 1'b0;
    check("mid_s", o_s(1'b0), 32'd1);
    check("mid_i", o_i(1'b0), 32'd1);
    check("mid_busy", o_busy(1'b0), 32'd1);
    check("mid_cnt1", o_cnt(1'b0, 1), 32'd1);
    pulse_reset;
    check("post_rst_s", o_s(1'b0), 32'd0);
    check("post_rst_i", o_i(1'b0), 32'd0);
    check("post_rst_busy", o_busy(1'b0), 32'd0);
    tick;
    check("no_replay_i", o_i(1'b0), 32'd0);
    check("no_replay_busy", o_busy(1'b0), 32'd0);
    send(1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 1'b0);
    check_counts(1'b0, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_demux_sel_sequencer
